rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_rf  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1  write request from requester 0 (ALU writeback) and requester 1 (load writeback).
REQ-006 SHALL have ports req0_addr, req1_addr  input  ADDR_W  destination register.
REQ-007 SHALL have ports req0_data, req1_data  input  DATA_W  write data.
REQ-008 SHALL have ports req0_ready, req1_ready  output  1  request accepted this cycle.
REQ-009 SHALL have port rf_we  output  1  register file write enable.
REQ-010 SHALL have port rf_adr3  output  ADDR_W  register file write address.
REQ-011 SHALL have port rf_wdata  output  DATA_W  register file write data.
REQ-012 SHALL have port last_grant  output  1  index of the most recently granted requester.

Function
REQ-013 SHALL transfer a request when reqN_valid and reqN_ready are both high at a rising clk edge.
REQ-014 SHALL assert at most one reqN_ready per cycle; each ready is combinational from the valids and last_grant only.
REQ-015 SHALL grant a sole valid requester in the same cycle.
REQ-016 SHALL, when both are valid, grant the requester not equal to last_grant (round-robin).
REQ-017 SHALL register the accepted address and data into an output stage; rf_we, rf_adr3 and rf_wdata reflect that transfer exactly one cycle later.
REQ-018 SHALL deassert rf_we in any cycle following a cycle with no transfer; rf_adr3 and rf_wdata hold their previous values.
REQ-019 SHALL accept writes addressed to register 0 (ready high) but SHALL keep rf_we low for them; last_grant still updates.
REQ-020 SHALL update last_grant only on a transfer, to the granted index.
REQ-021 SHALL, when both requesters target the same address in the same cycle, write the granted value first and the other value one cycle later, provided the loser holds valid; the final register content is the loser's data.
REQ-022 SHALL require a requester to hold valid, addr and data stable until ready; it SHALL NOT buffer a request that is not granted.
REQ-023 SHALL sustain one write per cycle with no bubbles under continuous requests.

Reset
REQ-024 SHALL, while reset_rf is high, force rf_we=0, rf_adr3=0, rf_wdata=0, last_grant=1 (requester 0 wins the first contention) and req0_ready=req1_ready=0.
REQ-025 SHALL discard a write captured in the output stage when reset_rf asserts; no rf_we pulse follows reset release without a new transfer.

Configuration
REQ-026 SHALL use macro RF_WRITE_ARB_FIXED_PRIO_EN: when defined, requester 1 (load) always wins contention and last_grant is still reported; when undefined, round-robin per REQ-016.

Structure
REQ-027 SHALL place ADDR_W/DATA_W defaults, the zero-register constant and the requester index constants (REQ_ALU=0, REQ_LSU=1) in shared package rf_pkg.
REQ-028 SHALL implement grant selection as sub-module rf_arb_grant (valids, last_grant in; one-hot grant out); output stage and last_grant register stay in rf_write_arbiter.

Verification
REQ-029 SHALL cover: req0 alone, addr=5 data=0xDEADBEEF -> req0_ready same cycle; next cycle rf_we=1, rf_adr3=5, rf_wdata=0xDEADBEEF.
REQ-030 SHALL cover: both valid after reset, addr 3/4 data 0x11/0x22 held -> cycle 1 grants req0, cycle 2 grants req1; rf_we high two consecutive cycles writing 3 then 4.
REQ-031 SHALL cover: both valid continuously for 8 cycles -> grants alternate 0,1,0,1...; with RF_WRITE_ARB_FIXED_PRIO_EN defined, req1 granted all 8 cycles.
REQ-032 SHALL cover: req1 addr=0 data=0xFFFFFFFF -> req1_ready=1, rf_we stays 0, last_grant=1.
REQ-033 SHALL cover: same address 7, req0 data 0xA, req1 data 0xB after reset -> writes 0xA then 0xB; register 7 ends 0xB.
REQ-034 SHALL cover: reset_rf pulsed in the cycle after a transfer -> rf_we=0 immediately and after release, last_grant=1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the register-file write arbiter: default widths,
// the hard-wired zero register, and the requester indices.
package rf_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int ZERO_REG   = 0;
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LSU  = 1'b1;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Request-side handshake bundle for the two register-file writeback requesters.
// master = requesters (ALU / load writeback), slave = the arbiter.
interface rf_write_arbiter_if
    import rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req0_valid;
    logic              req1_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req0_data;
    logic [DATA_W-1:0] req1_data;
    logic              req0_ready;
    logic              req1_ready;

    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/rf_arb_grant.sv
// Two-way grant selection: one-hot grant from the valids and the last winner.
// Macro RF_WRITE_ARB_FIXED_PRIO_EN makes requester 1 (load) win every contention.
module rf_arb_grant
    import rf_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
`ifdef RF_WRITE_ARB_FIXED_PRIO_EN
                grant = 2'b10;
`else
                // Round-robin: the requester that did not win last time goes now.
                grant = (last_grant == REQ_LSU) ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port
// through a one-cycle output stage. Optional macro: RF_WRITE_ARB_FIXED_PRIO_EN.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic               clk,
    input  logic               reset_rf,
    rf_write_arbiter_if.slave  req,
    output logic               rf_we,
    output logic [ADDR_W-1:0]  rf_adr3,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               last_grant
);
    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              xfer;
    logic              sel;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;

    assign valid = {req.req1_valid, req.req0_valid};

    rf_arb_grant u_grant (
        .valid      (valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is suppressed during reset so nothing is accepted and then lost.
    assign req.req0_ready = grant[REQ_ALU] & ~reset_rf;
    assign req.req1_ready = grant[REQ_LSU] & ~reset_rf;

    assign xfer     = req.req0_ready | req.req1_ready;
    assign sel      = grant[REQ_LSU];
    assign acc_addr = sel ? req.req1_addr : req.req0_addr;
    assign acc_data = sel ? req.req1_data : req.req0_data;

    always_ff @(posedge clk or posedge reset_rf) begin
        if (reset_rf) begin
            rf_we      <= 1'b0;
            rf_adr3    <= '0;
            rf_wdata   <= '0;
            last_grant <= REQ_LSU;
        end else if (xfer) begin
            // Writes to the zero register are accepted but never reach the file.
            rf_we      <= (acc_addr != ADDR_W'(ZERO_REG));
            rf_adr3    <= acc_addr;
            rf_wdata   <= acc_data;
            last_grant <= sel;
        end else begin
            rf_we      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter; expectations follow the build
// option RF_WRITE_ARB_FIXED_PRIO_EN when it is defined.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_rf = 1'b1;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_adr3;
    logic [DATA_W-1:0] rf_wdata;
    logic              last_grant;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] rf_model [32];

`ifdef RF_WRITE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    rf_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rf_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_rf   (reset_rf),
        .req        (bus.slave),
        .rf_we      (rf_we),
        .rf_adr3    (rf_adr3),
        .rf_wdata   (rf_wdata),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    endtask

    // One cycle: drive at negedge, check readies, clock, check the output stage.
    task automatic step(input string tag,
                        input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        input logic e_r0, input logic e_r1, input logic e_we,
                        input logic [ADDR_W-1:0] e_adr, input logic [DATA_W-1:0] e_dat,
                        input logic e_lg, input bit chk_ad);
        @(negedge clk);
        drive(v0, a0, d0, v1, a1, d1);
        #1;
        chk({tag, ".ready0"}, 64'(bus.req0_ready), 64'(e_r0));
        chk({tag, ".ready1"}, 64'(bus.req1_ready), 64'(e_r1));
        @(posedge clk);
        #1;
        chk({tag, ".we"}, 64'(rf_we), 64'(e_we));
        chk({tag, ".last_grant"}, 64'(last_grant), 64'(e_lg));
        if (chk_ad) begin
            chk({tag, ".adr"}, 64'(rf_adr3), 64'(e_adr));
            chk({tag, ".wdata"}, 64'(rf_wdata), 64'(e_dat));
        end
        if (rf_we) rf_model[rf_adr3] = rf_wdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_rf = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        reset_rf = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready0", 64'(bus.req0_ready), 64'd0);
        chk("rst.ready1", 64'(bus.req1_ready), 64'd0);
        chk("rst.we", 64'(rf_we), 64'd0);
        chk("rst.adr", 64'(rf_adr3), 64'd0);
        chk("rst.wdata", 64'(rf_wdata), 64'd0);
        chk("rst.last_grant", 64'(last_grant), 64'd1);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        reset_rf = 1'b0;

        // req0 alone, then an idle cycle: rf_we drops, address/data hold
        step("solo0", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 1);
        step("idle",  0, 5'd6, 32'h12345678, 0, 5'd0, 32'h0, 0, 0, 0, 5'd5, 32'hDEADBEEF, 0, 1);
        step("solo1", 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 1, 1, 5'd9, 32'h99, 1, 1);

        // Both valid after reset, each holds until granted
        do_reset();
        if (!FIXED) begin
            step("pair.c1", 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11, 0, 1);
            step("pair.c2", 0, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1, 1, 5'd4, 32'h22, 1, 1);
        end else begin
            step("pair.c1", 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1, 1, 5'd4, 32'h22, 1, 1);
            step("pair.c2", 1, 5'd3, 32'h11, 0, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11, 0, 1);
        end

        // Continuous contention for 8 cycles, no bubbles
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic g;
            g = FIXED ? 1'b1 : ((i % 2) == 1);
            step("stream", 1, 5'd1, 32'(i), 1, 5'd2, 32'(i + 100),
                 !g, g, 1, g ? 5'd2 : 5'd1, g ? 32'(i + 100) : 32'(i), g, 1);
        end

        // Zero-register write: accepted, no rf_we, last_grant updates to 1
        do_reset();
        step("z.pre", 1, 5'd8, 32'h8, 0, 5'd0, 32'h0, 1, 0, 1, 5'd8, 32'h8, 0, 1);
        step("z.r0",  0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF, 0, 1, 0, 5'd0, 32'h0, 1, 0);

        // Same address from both requesters; loser's data lands last
        do_reset();
        rf_model[7] = '0;
        if (!FIXED) begin
            step("same.c1", 1, 5'd7, 32'hA, 1, 5'd7, 32'hB, 1, 0, 1, 5'd7, 32'hA, 0, 1);
            step("same.c2", 0, 5'd7, 32'hA, 1, 5'd7, 32'hB, 0, 1, 1, 5'd7, 32'hB, 1, 1);
            chk("same.reg7", 64'(rf_model[7]), 64'hB);
        end else begin
            step("same.c1", 1, 5'd7, 32'hA, 1, 5'd7, 32'hB, 0, 1, 1, 5'd7, 32'hB, 1, 1);
            step("same.c2", 1, 5'd7, 32'hA, 0, 5'd7, 32'hB, 1, 0, 1, 5'd7, 32'hA, 0, 1);
            chk("same.reg7", 64'(rf_model[7]), 64'hA);
        end

        // Reset in the cycle after a transfer discards the pending write
        step("rp.xfer", 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 1, 0, 1, 5'd9, 32'h99, 0, 1);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        reset_rf = 1'b1;
        #1;
        chk("rp.we_now", 64'(rf_we), 64'd0);
        chk("rp.lg_now", 64'(last_grant), 64'd1);
        @(negedge clk);
        reset_rf = 1'b0;
        @(posedge clk);
        #1;
        chk("rp.we_after", 64'(rf_we), 64'd0);
        chk("rp.lg_after", 64'(last_grant), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
